// File: rtl/arb_mux_nbit.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux_nbit
// Function : N-input arbitrated mux (fixed-priority or round-robin) with a
//            single registered output stage and valid/ready handshakes.
// Revision : 1.0
// ============================================================================
module arb_mux_nbit #(
   parameter int MuxWidth  = 16,
   parameter int NumInputs = 4,
   parameter int ArbMode   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NumInputs-1:0]          in_valid,
   input  logic [NumInputs*MuxWidth-1:0] in_data,
   output logic [NumInputs-1:0]          in_ready,
   output logic                          out_valid,
   output logic [MuxWidth-1:0]           out_data,
   output logic [$clog2(NumInputs)-1:0]  out_sel,
   input  logic                          out_ready
);

   localparam int                   SelWidth   = $clog2(NumInputs);
   localparam logic [SelWidth-1:0]  c_LAST_IDX = SelWidth'(NumInputs - 1);

   logic                 r_valid;
   logic [MuxWidth-1:0]  r_data;
   logic [SelWidth-1:0]  r_sel;
   logic [SelWidth-1:0]  r_ptr;

   logic [MuxWidth-1:0]  w_ch [NumInputs];
   logic [NumInputs-1:0] w_grant;
   logic [SelWidth-1:0]  w_gidx;
   logic [SelWidth-1:0]  w_sel;
   logic                 w_found;
   logic                 w_load_en;
   logic                 w_xfer;
   int                   w_idx;

   for (genvar gi = 0; gi < NumInputs; gi++) begin : g_unpack
      assign w_ch[gi] = in_data[gi*MuxWidth +: MuxWidth];
   end

   // Search order starts at the pointer in round-robin mode, at 0 otherwise.
   always_comb begin
      w_grant = '0;
      w_gidx  = '0;
      w_sel   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 0; k < NumInputs; k++) begin
         w_idx = (ArbMode == 1) ? ((int'(r_ptr) + k) % NumInputs) : k;
         w_sel = w_idx[SelWidth-1:0];
         if (!w_found && in_valid[w_sel]) begin
            w_found        = 1'b1;
            w_grant[w_sel] = 1'b1;
            w_gidx         = w_sel;
         end
      end
   end

   assign w_load_en = !r_valid || out_ready;
   assign w_xfer    = w_load_en && w_found;
   assign in_ready  = w_load_en ? w_grant : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
         r_ptr   <= '0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_data  <= w_ch[w_gidx];
         r_sel   <= w_gidx;
         if (ArbMode == 1) begin
            r_ptr <= (w_gidx == c_LAST_IDX) ? '0 : w_gidx + 1'b1;
         end
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux_nbit.sv
`default_nettype none
// Testbench for arb_mux_nbit: a round-robin and a fixed-priority instance share
// stimulus; expected words are queued per instance and checked by a monitor.
module tb_arb_mux_nbit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [63:0] in_data;
   logic        out_ready;

   logic [3:0]  in_ready_rr, in_ready_fp;
   logic        ov_rr, ov_fp;
   logic [15:0] od_rr, od_fp;
   logic [1:0]  os_rr, os_fp;

   int n_tests = 0;
   int n_fail  = 0;

   logic [17:0] q_rr[$];
   logic [17:0] q_fp[$];

   localparam logic [15:0] D0 = 16'h1111, D1 = 16'h2222, D2 = 16'h3333, D3 = 16'h4444;

   always #5 clk = ~clk;

   arb_mux_nbit #(.MuxWidth(16), .NumInputs(4), .ArbMode(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_rr), .out_valid(ov_rr), .out_data(od_rr),
      .out_sel(os_rr), .out_ready(out_ready));

   arb_mux_nbit #(.MuxWidth(16), .NumInputs(4), .ArbMode(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_fp), .out_valid(ov_fp), .out_data(od_fp),
      .out_sel(os_fp), .out_ready(out_ready));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected {sel,data} per output transfer.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("rr_onehot", {31'd0, $countones(in_ready_rr) <= 1}, 32'd1);
         chk("fp_onehot", {31'd0, $countones(in_ready_fp) <= 1}, 32'd1);
         if (ov_rr && out_ready) begin
            if (q_rr.size() == 0) chk("rr_unexpected_out", {14'd0, os_rr, od_rr}, 32'hFFFF_FFFF);
            else chk("rr_out", {14'd0, os_rr, od_rr}, {14'd0, q_rr.pop_front()});
         end
         if (ov_fp && out_ready) begin
            if (q_fp.size() == 0) chk("fp_unexpected_out", {14'd0, os_fp, od_fp}, 32'hFFFF_FFFF);
            else chk("fp_out", {14'd0, os_fp, od_fp}, {14'd0, q_fp.pop_front()});
         end
      end
   end

   function automatic int rr_pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic int fp_pick(input logic [3:0] v);
      for (int k = 0; k < 4; k++) if (v[k]) return k;
      return -1;
   endfunction

   initial begin
      int          m_ptr;
      logic        m_ov_rr, m_ov_fp;
      int          g;
      logic [3:0]  exp_rdy;

      // Reset with every channel requesting
      rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
      in_data = {D3, D2, D1, D0};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ov", {31'd0, ov_rr}, 32'd0);
      chk("rst_od", {16'd0, od_rr}, 32'd0);
      chk("rst_os", {30'd0, os_rr}, 32'd0);
      chk("rst_fp_ov", {31'd0, ov_fp}, 32'd0);
      chk("rst_rdy_rr", {28'd0, in_ready_rr}, 32'h1);
      chk("rst_rdy_fp", {28'd0, in_ready_fp}, 32'h1);
      q_rr.push_back({2'd0, D0}); q_rr.push_back({2'd1, D1}); q_rr.push_back({2'd2, D2});
      q_rr.push_back({2'd3, D3}); q_rr.push_back({2'd0, D0}); q_rr.push_back({2'd1, D1});
      repeat (6) q_fp.push_back({2'd0, D0});
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("rr_stream_valid", {31'd0, ov_rr}, 32'd1);
      end

      // Channels 1 and 3 requesting; rr pointer currently at 2
      in_valid = 4'b1010;
      q_rr.push_back({2'd3, D3}); q_rr.push_back({2'd1, D1});
      q_rr.push_back({2'd3, D3}); q_rr.push_back({2'd1, D1});
      repeat (4) q_fp.push_back({2'd1, D1});
      repeat (4) @(posedge clk);
      #1;

      // Pointer walk 2 -> 3, wrap to channel 0 (ptr 1), then 1001 grants 3
      in_valid = 4'b0100;
      q_rr.push_back({2'd2, D2}); q_fp.push_back({2'd2, D2});
      @(posedge clk); #1;
      in_valid = 4'b0001;
      q_rr.push_back({2'd0, D0}); q_fp.push_back({2'd0, D0});
      @(posedge clk); #1;
      in_valid = 4'b1001;
      q_rr.push_back({2'd3, D3}); q_fp.push_back({2'd0, D0});
      @(posedge clk); #1;
      in_valid = 4'b0000;
      @(posedge clk); #1;

      // Stall with A5A5 held while channel 2 waits
      in_valid = 4'b0010; out_ready = 1'b0;
      in_data = {D3, D2, 16'hA5A5, D0};
      q_rr.push_back({2'd1, 16'hA5A5}); q_rr.push_back({2'd2, D2});
      q_fp.push_back({2'd1, 16'hA5A5}); q_fp.push_back({2'd2, D2});
      @(posedge clk); #1;
      in_valid = 4'b0100; in_data = {D3, D2, D1, D0};
      for (int i = 0; i < 3; i++) begin
         chk("stall_od", {16'd0, od_rr}, 32'h0000_A5A5);
         chk("stall_ov", {31'd0, ov_rr}, 32'd1);
         chk("stall_rdy_rr", {28'd0, in_ready_rr}, 32'd0);
         chk("stall_rdy_fp", {28'd0, in_ready_fp}, 32'd0);
         @(posedge clk); #1;
      end
      chk("stall_od_end", {16'd0, od_rr}, 32'h0000_A5A5);
      out_ready = 1'b1; #1;
      chk("release_rdy_rr", {28'd0, in_ready_rr}, 32'b0100);
      @(posedge clk); #1;
      chk("release_od", {16'd0, od_rr}, {16'd0, D2});
      chk("release_os", {30'd0, os_rr}, 32'd2);
      in_valid = 4'b0000;
      @(posedge clk); #1;

      // Reset while a word is held discards it
      in_valid = 4'b0001; out_ready = 1'b0;
      @(posedge clk); #1;
      chk("held_ov", {31'd0, ov_rr}, 32'd1);
      rst_n = 1'b0; #1;
      chk("midrst_ov", {31'd0, ov_rr}, 32'd0);
      chk("midrst_od", {16'd0, od_rr}, 32'd0);
      in_valid = 4'hF; out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      q_rr.push_back({2'd0, D0}); q_fp.push_back({2'd0, D0});
      @(posedge clk); #1;
      in_valid = 4'b0000;
      @(posedge clk); #1;

      // Random traffic against an arbitration model
      m_ptr = 1; m_ov_rr = 1'b0; m_ov_fp = 1'b0;
      for (int c = 0; c < 400; c++) begin
         in_valid  = 4'($urandom);
         in_data   = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         chk("rnd_ov_rr", {31'd0, ov_rr}, {31'd0, m_ov_rr});
         g = rr_pick(in_valid, m_ptr);
         exp_rdy = ((!m_ov_rr || out_ready) && g >= 0) ? 4'(1 << g) : 4'd0;
         chk("rnd_rdy_rr", {28'd0, in_ready_rr}, {28'd0, exp_rdy});
         if (exp_rdy != 0) begin
            q_rr.push_back({2'(g), in_data[g*16 +: 16]});
            m_ptr = (g + 1) % 4; m_ov_rr = 1'b1;
         end else if (out_ready) m_ov_rr = 1'b0;
         g = fp_pick(in_valid);
         exp_rdy = ((!m_ov_fp || out_ready) && g >= 0) ? 4'(1 << g) : 4'd0;
         chk("rnd_rdy_fp", {28'd0, in_ready_fp}, {28'd0, exp_rdy});
         if (exp_rdy != 0) begin
            q_fp.push_back({2'(g), in_data[g*16 +: 16]});
            m_ov_fp = 1'b1;
         end else if (out_ready) m_ov_fp = 1'b0;
         @(posedge clk); #1;
      end

      in_valid = 4'b0000; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rr_queue_empty", q_rr.size(), 32'd0);
      chk("fp_queue_empty", q_fp.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
